// File: rtl/tdpram_core.sv
// True dual-port RAM core with a post-reset clear sweep, registered read ports
// (1-cycle latency), write-first on the same port and read-before-write across
// ports. Same-address accesses involving a write are counted as collisions.
module tdpram_core #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // Port A (we_a active-low: 0 = write, 1 = read)
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  // Port B (we_b active-low: 0 = write, 1 = read)
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  // Status
  output logic              ready,
  output logic              coll,
  output logic [7:0]        coll_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SweepLast = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] sweep_q, sweep_d;

  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;
  logic              coll_q, coll_d;
  logic [7:0]        coll_cnt_q, coll_cnt_d;

  logic [DATA_W-1:0] mem_q [Depth];

  // Decoded access qualifiers
  logic in_ready;
  logic in_init;
  logic acc_a_wr;
  logic acc_b_wr;
  logic same_addr;

  // Memory write ports: port 0 is shared by the clear sweep and port A
  logic              mem_we0;
  logic [ADDR_W-1:0] mem_waddr0;
  logic [DATA_W-1:0] mem_wdata0;
  logic              mem_we1;
  logic [ADDR_W-1:0] mem_waddr1;
  logic [DATA_W-1:0] mem_wdata1;

  // Access decode; all port activity is masked until the sweep has finished
  always_comb begin
    in_ready  = (state_q == StReady);
    in_init   = (state_q == StInit);
    acc_a_wr  = in_ready & ~we_a;
    acc_b_wr  = in_ready & ~we_b;
    same_addr = (addr_a == addr_b);
  end

  // FSM next state: sweep one word per cycle, then hold READY until reset
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      StInit: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == SweepLast) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StInit;
        sweep_d = '0;
      end
    endcase
  end

  // Memory write steering; nothing is written in a reset cycle
  always_comb begin
    mem_we0    = 1'b0;
    mem_waddr0 = addr_a;
    mem_wdata0 = din_a;
    mem_we1    = 1'b0;
    mem_waddr1 = addr_b;
    mem_wdata1 = din_b;

    if (in_init) begin
      mem_we0    = rst_n;
      mem_waddr0 = sweep_q;
      mem_wdata0 = '0;
    end else begin
      mem_we0 = rst_n & acc_a_wr;
    end

    // Port A wins when both ports write the same word
    mem_we1 = rst_n & acc_b_wr & ~(acc_a_wr & same_addr);
  end

  // Read data and collision tracking next state
  always_comb begin
    dout_a_d   = '0;
    dout_b_d   = '0;
    coll_d     = 1'b0;
    coll_cnt_d = coll_cnt_q;

    if (in_ready) begin
      // Own-port write shows the new data; otherwise the pre-edge contents,
      // which gives read-before-write against the other port
      dout_a_d = acc_a_wr ? din_a : mem_q[addr_a];
      dout_b_d = acc_b_wr ? din_b : mem_q[addr_b];

      coll_d = same_addr & (acc_a_wr | acc_b_wr);
      if (coll_d && (coll_cnt_q != 8'hFF)) begin
        coll_cnt_d = coll_cnt_q + 8'd1;
      end
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      coll_q     <= 1'b0;
      coll_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  // Storage array; contents are cleared by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we0) begin
      mem_q[mem_waddr0] <= mem_wdata0;
    end
    if (mem_we1) begin
      mem_q[mem_waddr1] <= mem_wdata1;
    end
  end

  assign ready    = in_ready;
  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;
  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_tdpram_core.sv
// Directed bench for tdpram_core: table of single-cycle vectors plus
// hand-written sequences for the reset sweep, saturation and mid-sweep reset.
module tb_tdpram_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we_a;
  logic [3:0] addr_a;
  logic [7:0] din_a;
  logic [7:0] dout_a;
  logic       we_b;
  logic [3:0] addr_b;
  logic [7:0] din_b;
  logic [7:0] dout_b;
  logic       ready;
  logic       coll;
  logic [7:0] coll_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tdpram_core #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .din_a   (din_a),
    .dout_a  (dout_a),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .din_b   (din_b),
    .dout_b  (dout_b),
    .ready   (ready),
    .coll    (coll),
    .coll_cnt(coll_cnt)
  );

  typedef struct {
    logic       we_a;
    logic [3:0] addr_a;
    logic [7:0] din_a;
    logic       we_b;
    logic [3:0] addr_b;
    logic [7:0] din_b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_coll;
    logic [7:0] exp_cnt;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change after a falling edge; outputs are sampled on the next one
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic wb, input logic [3:0] ab, input logic [7:0] db);
    we_a   = wa;
    addr_a = aa;
    din_a  = da;
    we_b   = wb;
    addr_b = ab;
    din_b  = db;
  endtask

  task automatic add(input logic wa, input logic [3:0] aa, input logic [7:0] da,
                     input logic wb, input logic [3:0] ab, input logic [7:0] db,
                     input logic [7:0] ea, input logic [7:0] eb, input logic ec,
                     input logic [7:0] en, input string tag);
    vec_t v;
    v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.exp_a = ea; v.exp_b = eb; v.exp_coll = ec; v.exp_cnt = en;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout_a"}, dout_a, 0);
    check({tag, "_dout_b"}, dout_b, 0);
    check({tag, "_coll"}, coll, 0);
    check({tag, "_cnt"}, coll_cnt, 0);
  endtask

  logic [7:0] wdat1 [6];
  logic [7:0] wdat2 [6];

  initial begin
    wdat1 = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D};
    wdat2 = '{8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86};

    // Clear check: every word reads zero on A, B parked on 15
    for (int i = 0; i < 16; i++) begin
      add(1'b1, 4'(i), 8'h00, 1'b1, 4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 8'd0,
          $sformatf("clr_rd%0d", i));
    end
    // Port A writes then reads back
    for (int i = 0; i < 6; i++) begin
      add(1'b0, 4'(i), wdat1[i], 1'b1, 4'd15, 8'h00, wdat1[i], 8'h00, 1'b0, 8'd0,
          $sformatf("a_wr%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      add(1'b1, 4'(i), 8'h00, 1'b1, 4'd15, 8'h00, wdat1[i], 8'h00, 1'b0, 8'd0,
          $sformatf("a_rd%0d", i));
    end
    // Port A writes addr k while B reads addr k-1
    for (int i = 0; i < 6; i++) begin
      add(1'b0, 4'(i), wdat2[i], 1'b1, (i == 0) ? 4'd15 : 4'(i - 1), 8'h00,
          wdat2[i], (i == 0) ? 8'h00 : wdat2[i-1], 1'b0, 8'd0,
          $sformatf("ab_pipe%0d", i));
    end
    add(1'b1, 4'd15, 8'h00, 1'b1, 4'd5, 8'h00, 8'h00, wdat2[5], 1'b0, 8'd0, "ab_pipe6");
    // Same-address collisions
    add(1'b0, 4'd3, 8'hAA, 1'b0, 4'd3, 8'h55, 8'hAA, 8'h55, 1'b1, 8'd1, "coll_ww");
    add(1'b1, 4'd3, 8'h00, 1'b1, 4'd7, 8'h00, 8'hAA, 8'h00, 1'b0, 8'd1, "coll_ww_rd");
    add(1'b1, 4'd3, 8'h00, 1'b0, 4'd3, 8'h99, 8'hAA, 8'h99, 1'b1, 8'd2, "coll_rw");
    add(1'b1, 4'd3, 8'h00, 1'b1, 4'd3, 8'h00, 8'h99, 8'h99, 1'b0, 8'd2, "dual_rd");
    // Independent simultaneous writes to different addresses
    add(1'b0, 4'd10, 8'h5A, 1'b0, 4'd11, 8'hA5, 8'h5A, 8'hA5, 1'b0, 8'd2, "indep_ww");
    add(1'b1, 4'd11, 8'h00, 1'b1, 4'd10, 8'h00, 8'hA5, 8'h5A, 1'b0, 8'd2, "indep_rd");

    // Reset with writes presented; both ports hit address 5
    rst_n = 1'b0;
    drive(1'b0, 4'd5, 8'h77, 1'b0, 4'd5, 8'h66);
    step();
    step();
    check("rst_ready", ready, 0);
    check_idle("rst");

    // Sweep: inputs keep trying to write and collide, all must be ignored
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      check($sformatf("init_ready%0d", n), ready, (n == 16) ? 1 : 0);
      check_idle($sformatf("init%0d", n));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].we_a, vecs[i].addr_a, vecs[i].din_a,
            vecs[i].we_b, vecs[i].addr_b, vecs[i].din_b);
      step();
      check({vecs[i].tag, "_dout_a"}, dout_a, vecs[i].exp_a);
      check({vecs[i].tag, "_dout_b"}, dout_b, vecs[i].exp_b);
      check({vecs[i].tag, "_coll"}, coll, vecs[i].exp_coll);
      check({vecs[i].tag, "_cnt"}, coll_cnt, vecs[i].exp_cnt);
    end

    // 300 back-to-back collisions: A writes addr 9, B reads the old value
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 4'd9, i[7:0], 1'b1, 4'd9, 8'h00);
      step();
      check($sformatf("sat_coll%0d", i), coll, 1);
      check($sformatf("sat_cnt%0d", i), coll_cnt, (3 + i > 255) ? 255 : 3 + i);
      check($sformatf("sat_dout_b%0d", i), dout_b, (i == 0) ? 0 : ((i - 1) & 8'hFF));
    end
    drive(1'b1, 4'd9, 8'h00, 1'b1, 4'd9, 8'h00);
    step();
    check("sat_dual_coll", coll, 0);
    check("sat_dual_cnt", coll_cnt, 255);
    check("sat_dual_a", dout_a, 8'h2B);
    check("sat_dual_b", dout_b, 8'h2B);

    // Write 0x7E to addr 5, then reset from READY with a write presented
    drive(1'b0, 4'd5, 8'h7E, 1'b1, 4'd0, 8'h00);
    step();
    check("pre_rst_wr", dout_a, 8'h7E);
    rst_n = 1'b0;
    drive(1'b0, 4'd6, 8'hEE, 1'b1, 4'd0, 8'h00);
    step();
    check("rst2_ready", ready, 0);
    check_idle("rst2");

    // Start a sweep, interrupt it at address 8, with INIT-time writes presented
    rst_n = 1'b1;
    drive(1'b0, 4'd5, 8'h7E, 1'b0, 4'd12, 8'h33);
    for (int n = 1; n <= 8; n++) begin
      step();
      check($sformatf("part_ready%0d", n), ready, 0);
    end
    rst_n = 1'b0;
    step();
    check("mid_rst_ready", ready, 0);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      check($sformatf("resweep_ready%0d", n), ready, (n == 16) ? 1 : 0);
      check_idle($sformatf("resweep%0d", n));
    end

    drive(1'b1, 4'd5, 8'h00, 1'b1, 4'd12, 8'h00);
    step();
    check("post_a5", dout_a, 0);
    check("post_b12", dout_b, 0);
    drive(1'b1, 4'd6, 8'h00, 1'b1, 4'd9, 8'h00);
    step();
    check("post_a6", dout_a, 0);
    check("post_b9", dout_b, 0);
    check("post_cnt", coll_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdpram_core.md
TDPRAM_CORE -- requirements
Module: tdpram_core

Interface
REQ-001 Parameters SHALL be: ADDR_W, 4, address width (depth 2**ADDR_W); DATA_W, 8, data width per word.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 we_a  input  1  port A write enable, active-low (0 = write, 1 = read).
REQ-005 addr_a  input  ADDR_W  port A address.
REQ-006 din_a  input  DATA_W  port A write data.
REQ-007 dout_a  output  DATA_W  port A registered read data.
REQ-008 we_b  input  1  port B write enable, active-low (0 = write, 1 = read).
REQ-009 addr_b  input  ADDR_W  port B address.
REQ-010 din_b  input  DATA_W  port B write data.
REQ-011 dout_b  output  DATA_W  port B registered read data.
REQ-012 ready  output  1  high once the post-reset clear sweep is complete.
REQ-013 coll  output  1  one-cycle pulse on an address collision.
REQ-014 coll_cnt  output  8  saturating collision count.

Function
REQ-015 State machine SHALL have two states, INIT and READY; INIT -> READY after the last sweep write; READY SHALL hold until reset.
REQ-016 In INIT, one word per cycle SHALL be written to 0, addresses 0 .. 2**ADDR_W-1 ascending, using an internal sweep counter.
REQ-017 ready SHALL assert the cycle after the write to address 2**ADDR_W-1, i.e. 2**ADDR_W cycles after rst_n deasserts (16 for defaults).
REQ-018 While ready=0, port inputs SHALL be ignored: no memory writes, dout_a/dout_b held at 0, coll=0, coll_cnt unchanged.
REQ-019 Write (ready=1, we_x=0): mem[addr_x] <= din_x at the edge; dout_x SHALL show din_x the next cycle (write-first on the same port).
REQ-020 Read (ready=1, we_x=1): dout_x SHALL show mem[addr_x] one cycle after the sampling edge; latency is fixed at 1.
REQ-021 Cross-port read of an address written by the other port in the same cycle SHALL return the old contents (read-before-write).
REQ-022 Both ports writing the same address in the same cycle: port A data SHALL be stored; each port's dout SHALL show its own din.
REQ-023 Collision = ready=1, addr_a==addr_b, and at least one of we_a/we_b low; coll SHALL pulse high the following cycle.
REQ-024 Two reads of the same address SHALL NOT count as a collision.
REQ-025 coll_cnt SHALL increment by 1 per collision and saturate at 255 (no wrap).
REQ-026 Accesses to different addresses SHALL be fully independent, including simultaneous writes.

Reset
REQ-027 rst_n=0 at an edge SHALL set: state INIT, sweep counter 0, ready=0, dout_a=0, dout_b=0, coll=0, coll_cnt=0.
REQ-028 Reset asserted mid-sweep or in READY SHALL restart the sweep from address 0; memory SHALL end all-zero after the new sweep.
REQ-029 Writes presented in the same cycle as rst_n=0 SHALL be discarded.

Verification
REQ-030 Reset then idle: ready=0 for 16 cycles, ready=1 from cycle 17; reading addresses 0..15 on port A returns 0x00 each.
REQ-031 Port A writes 0x24,0x81,0x09,0x63,0x0D,0x8D to addresses 0..5, then port A reads 0..5 -> same bytes, each 1 cycle after its address; coll stays 0.
REQ-032 Port A writes addresses 0..5 while port B reads each address one cycle later -> dout_b matches the written byte with 1-cycle latency.
REQ-033 Same cycle: A writes 0xAA and B writes 0x55 to address 3 -> coll pulses once, coll_cnt=1, subsequent read of address 3 = 0xAA; A read + B write same address -> dout_a old value, coll_cnt=2.
REQ-034 300 consecutive collisions -> coll_cnt saturates at 255; dual reads of the same address -> coll stays 0.
REQ-035 Write 0x7E to address 5, assert rst_n=0 at sweep address 8, release -> ready returns after 16 cycles, address 5 reads 0x00, writes issued during INIT have no effect.
